writeback_commit: RTL and testbench



---
 rtl/writeback_commit.sv | 237 +++++++++++++++++++++++
 tb/tb_writeback_commit.sv | 615 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_commit.sv
// writeback_commit: final pipeline stage. It retires instructions and drives the GPR and CSR
// write ports. Normal instructions commit in one cycle. Traps and mret step through a small FSM
// that serialises the machine-mode CSR updates over the single CSR write port, then redirects
// and flushes fetch.
// Optional feature: define WB_INSTRET_EN to add the 64-bit retired-instruction counter `instret`.
module writeback_commit #(
    parameter int unsigned     XLEN             = 64,
    parameter logic [XLEN-1:0] MTVEC_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_regwrite,
    input  logic [4:0]      in_dst,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_csrwrite,
    input  logic [11:0]     in_csraddr,
    input  logic [XLEN-1:0] in_csrdata,
    input  logic            in_exception,
    input  logic [XLEN-1:0] in_cause,
    input  logic [XLEN-1:0] in_tval,
    input  logic            in_mret,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mstatus,
    output logic            wen,
    output logic [4:0]      wa,
    output logic [XLEN-1:0] wd,
    output logic            csr_wen,
    output logic [11:0]     csr_wa,
    output logic [XLEN-1:0] csr_wd,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // Each state names the CSR write that is on the output port while the state is current.
    typedef enum logic [2:0] {
        StIdle,
        StTEpc,
        StTCause,
        StTTval,
        StTStatus,
        StMStatus
    } state_e;

    state_e          r_state, w_state_next;
    logic [XLEN-1:0] r_cap_cause, w_cap_cause_next;
    logic [XLEN-1:0] r_cap_tval, w_cap_tval_next;

    logic            r_wen, w_wen_next;
    logic [4:0]      r_wa, w_wa_next;
    logic [XLEN-1:0] r_wd, w_wd_next;
    logic            r_csr_wen, w_csr_wen_next;
    logic [11:0]     r_csr_wa, w_csr_wa_next;
    logic [XLEN-1:0] r_csr_wd, w_csr_wd_next;
    logic            r_redirect_valid, w_redirect_valid_next;
    logic [XLEN-1:0] r_redirect_pc, w_redirect_pc_next;
    logic            r_flush, w_flush_next;
    logic            r_commit_valid, w_commit_valid_next;
    logic [XLEN-1:0] r_commit_pc, w_commit_pc_next;

    // Trap entry: stash MIE into MPIE, clear MIE, record M-mode as previous privilege.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] v;
        v        = s;
        v[7]     = s[3];
        v[3]     = 1'b0;
        v[12:11] = 2'b11;
        return v;
    endfunction

    // Trap return: restore MIE from MPIE, set MPIE, previous privilege back to U.
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] v;
        v        = s;
        v[3]     = s[7];
        v[7]     = 1'b1;
        v[12:11] = 2'b00;
        return v;
    endfunction

    assign in_ready = (r_state == StIdle);

    // Next state and next registered outputs; strobes default low, data fields hold.
    always_comb begin
        w_state_next          = r_state;
        w_cap_cause_next      = r_cap_cause;
        w_cap_tval_next       = r_cap_tval;
        w_wen_next            = 1'b0;
        w_wa_next             = r_wa;
        w_wd_next             = r_wd;
        w_csr_wen_next        = 1'b0;
        w_csr_wa_next         = r_csr_wa;
        w_csr_wd_next         = r_csr_wd;
        w_redirect_valid_next = 1'b0;
        w_redirect_pc_next    = r_redirect_pc;
        w_flush_next          = 1'b0;
        w_commit_valid_next   = 1'b0;
        w_commit_pc_next      = r_commit_pc;

        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    if (in_exception) begin
                        // The mepc write goes out immediately; cause and tval wait their turn.
                        w_state_next     = StTEpc;
                        w_cap_cause_next = in_cause;
                        w_cap_tval_next  = in_tval;
                        w_csr_wen_next   = 1'b1;
                        w_csr_wa_next    = CSR_MEPC;
                        w_csr_wd_next    = in_pc;
                    end else if (in_mret) begin
                        w_state_next          = StMStatus;
                        w_csr_wen_next        = 1'b1;
                        w_csr_wa_next         = CSR_MSTATUS;
                        w_csr_wd_next         = mret_mstatus(mstatus);
                        w_redirect_valid_next = 1'b1;
                        w_redirect_pc_next    = mepc;
                        w_flush_next          = 1'b1;
                        w_commit_valid_next   = 1'b1;
                        w_commit_pc_next      = in_pc;
                    end else begin
                        w_wen_next          = in_regwrite && (in_dst != 5'd0);
                        w_wa_next           = in_dst;
                        w_wd_next           = in_result;
                        w_csr_wen_next      = in_csrwrite;
                        w_csr_wa_next       = in_csraddr;
                        w_csr_wd_next       = in_csrdata;
                        w_commit_valid_next = 1'b1;
                        w_commit_pc_next    = in_pc;
                    end
                end
            end
            StTEpc: begin
                w_state_next   = StTCause;
                w_csr_wen_next = 1'b1;
                w_csr_wa_next  = CSR_MCAUSE;
                w_csr_wd_next  = r_cap_cause;
            end
            StTCause: begin
                w_state_next   = StTTval;
                w_csr_wen_next = 1'b1;
                w_csr_wa_next  = CSR_MTVAL;
                w_csr_wd_next  = r_cap_tval;
            end
            StTTval: begin
                w_state_next          = StTStatus;
                w_csr_wen_next        = 1'b1;
                w_csr_wa_next         = CSR_MSTATUS;
                w_csr_wd_next         = trap_mstatus(mstatus);
                w_redirect_valid_next = 1'b1;
                w_redirect_pc_next    = mtvec & MTVEC_ALIGN_MASK;
                w_flush_next          = 1'b1;
            end
            StTStatus: w_state_next = StIdle;
            StMStatus: w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // State, capture and output registers; reset abandons any trap sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= StIdle;
            r_cap_cause      <= '0;
            r_cap_tval       <= '0;
            r_wen            <= 1'b0;
            r_wa             <= '0;
            r_wd             <= '0;
            r_csr_wen        <= 1'b0;
            r_csr_wa         <= '0;
            r_csr_wd         <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_commit_valid   <= 1'b0;
            r_commit_pc      <= '0;
        end else begin
            r_state          <= w_state_next;
            r_cap_cause      <= w_cap_cause_next;
            r_cap_tval       <= w_cap_tval_next;
            r_wen            <= w_wen_next;
            r_wa             <= w_wa_next;
            r_wd             <= w_wd_next;
            r_csr_wen        <= w_csr_wen_next;
            r_csr_wa         <= w_csr_wa_next;
            r_csr_wd         <= w_csr_wd_next;
            r_redirect_valid <= w_redirect_valid_next;
            r_redirect_pc    <= w_redirect_pc_next;
            r_flush          <= w_flush_next;
            r_commit_valid   <= w_commit_valid_next;
            r_commit_pc      <= w_commit_pc_next;
        end
    end

    assign wen            = r_wen;
    assign wa             = r_wa;
    assign wd             = r_wd;
    assign csr_wen        = r_csr_wen;
    assign csr_wa         = r_csr_wa;
    assign csr_wd         = r_csr_wd;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_flush;
    assign commit_valid   = r_commit_valid;
    assign commit_pc      = r_commit_pc;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    // Count every retirement pulse (normal and mret); wraps naturally past 2^64-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= '0;
        end else if (r_commit_valid) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

endmodule

// File: tb/tb_writeback_commit.sv
// Self-checking bench for writeback_commit: directed scenarios from the block's test plan plus a
// randomized stream checked against a cycle-by-cycle expected-event queue.
module tb_writeback_commit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic        in_regwrite;
    logic [4:0]  in_dst;
    logic [63:0] in_result;
    logic        in_csrwrite;
    logic [11:0] in_csraddr;
    logic [63:0] in_csrdata;
    logic        in_exception;
    logic [63:0] in_cause;
    logic [63:0] in_tval;
    logic        in_mret;
    logic [63:0] mtvec;
    logic [63:0] mepc;
    logic [63:0] mstatus;
    logic        wen;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        csr_wen;
    logic [11:0] csr_wa;
    logic [63:0] csr_wd;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush;
    logic        commit_valid;
    logic [63:0] commit_pc;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int n_checks;
    int n_fail;

    // One expected output cycle.
    typedef struct packed {
        logic        wen;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        csr_wen;
        logic [11:0] csr_wa;
        logic [63:0] csr_wd;
        logic        rv;
        logic [63:0] rpc;
        logic        flush;
        logic        cv;
        logic [63:0] cpc;
        logic        rdy;
    } rec_t;

    writeback_commit dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_regwrite    (in_regwrite),
        .in_dst         (in_dst),
        .in_result      (in_result),
        .in_csrwrite    (in_csrwrite),
        .in_csraddr     (in_csraddr),
        .in_csrdata     (in_csrdata),
        .in_exception   (in_exception),
        .in_cause       (in_cause),
        .in_tval        (in_tval),
        .in_mret        (in_mret),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .mstatus        (mstatus),
        .wen            (wen),
        .wa             (wa),
        .wd             (wd),
        .csr_wen        (csr_wen),
        .csr_wa         (csr_wa),
        .csr_wd         (csr_wd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc)
`ifdef WB_INSTRET_EN
        ,
        .instret        (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rules for mstatus, written as mask-and-merge arithmetic.
    function automatic logic [63:0] model_trap_status(input logic [63:0] s);
        return (s & ~64'h1888) | ({63'd0, s[3]} << 7) | 64'h1800;
    endfunction

    function automatic logic [63:0] model_mret_status(input logic [63:0] s);
        return (s & ~64'h1888) | ({63'd0, s[7]} << 3) | 64'h80;
    endfunction

    task automatic drive_idle();
        in_valid     = 1'b0;
        in_pc        = '0;
        in_regwrite  = 1'b0;
        in_dst       = '0;
        in_result    = '0;
        in_csrwrite  = 1'b0;
        in_csraddr   = '0;
        in_csrdata   = '0;
        in_exception = 1'b0;
        in_cause     = '0;
        in_tval      = '0;
        in_mret      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({wen, csr_wen, redirect_valid, flush, commit_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {wen, csr_wen, redirect_valid, flush, commit_valid});
        end
        n_checks++;
        if ((wd | csr_wd | redirect_pc | commit_pc) !== 64'd0 || wa !== 5'd0 || csr_wa !== 12'd0)
        begin
            n_fail++;
            $display("FAIL reset_data: got nonzero data outputs, expected all 0");
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
`ifdef WB_INSTRET_EN
        n_checks++;
        if (instret !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_instret: got %0d expected 0", instret);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({wen, csr_wen, redirect_valid, flush, commit_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL idle_strobes: got %b expected 00000",
                     {wen, csr_wen, redirect_valid, flush, commit_valid});
        end
    endtask

    task automatic test_normal();
        in_valid    = 1'b1;
        in_pc       = 64'h1000;
        in_regwrite = 1'b1;
        in_dst      = 5'd5;
        in_result   = 64'h1234;
        @(negedge clk);
        n_checks++;
        if (wen !== 1'b1 || wa !== 5'd5 || wd !== 64'h1234) begin
            n_fail++;
            $display("FAIL normal_gpr: got wen=%b wa=%0d wd=%h expected 1 5 1234", wen, wa, wd);
        end
        n_checks++;
        if (commit_valid !== 1'b1 || commit_pc !== 64'h1000) begin
            n_fail++;
            $display("FAIL normal_commit: got cv=%b pc=%h expected 1 1000", commit_valid, commit_pc);
        end
        n_checks++;
        if ({csr_wen, redirect_valid, flush} !== 3'b0) begin
            n_fail++;
            $display("FAIL normal_other: got %b expected 000", {csr_wen, redirect_valid, flush});
        end
        in_dst = 5'd0;
        in_pc  = 64'h1004;
        @(negedge clk);
        n_checks++;
        if (wen !== 1'b0 || commit_valid !== 1'b1 || commit_pc !== 64'h1004) begin
            n_fail++;
            $display("FAIL x0_suppress: got wen=%b cv=%b pc=%h expected 0 1 1004",
                     wen, commit_valid, commit_pc);
        end
        drive_idle();
        @(negedge clk);
        n_checks++;
        if ({wen, csr_wen, commit_valid} !== 3'b0) begin
            n_fail++;
            $display("FAIL normal_pulse: got %b expected 000", {wen, csr_wen, commit_valid});
        end
    endtask

    task automatic test_back_to_back();
        int   pulses;
        logic ready_ok;
        pulses   = 0;
        ready_ok = 1'b1;
        do_reset();
`ifdef WB_INSTRET_EN
        n_checks++;
        if (instret !== 64'd0) begin
            n_fail++;
            $display("FAIL b2b_instret_start: got %0d expected 0", instret);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'b1;
            in_pc       = 64'h2000 + 64'(4 * i);
            in_regwrite = 1'b1;
            in_dst      = 5'(i + 1);
            in_result   = 64'(i);
            @(negedge clk);
            if (commit_valid === 1'b1 && commit_pc === 64'h2000 + 64'(4 * i)) pulses++;
            if (in_ready !== 1'b1) ready_ok = 1'b0;
        end
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d expected 3", pulses);
        end
        n_checks++;
        if (ready_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got in_ready low expected held 1");
        end
        n_checks++;
        if (commit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got cv=%b expected 0", commit_valid);
        end
`ifdef WB_INSTRET_EN
        n_checks++;
        if (instret !== 64'd3) begin
            n_fail++;
            $display("FAIL b2b_instret: got %0d expected 3", instret);
        end
`endif
    endtask

    task automatic test_trap();
        logic [11:0] exp_wa [4];
        logic [63:0] exp_wd [4];
        logic [63:0] ir0;
        exp_wa[0] = 12'h341; exp_wd[0] = 64'h8000_0010;
        exp_wa[1] = 12'h342; exp_wd[1] = 64'd2;
        exp_wa[2] = 12'h343; exp_wd[2] = 64'hdead;
        exp_wa[3] = 12'h300; exp_wd[3] = 64'h1880;
        ir0 = '0;
`ifdef WB_INSTRET_EN
        ir0 = instret;
`endif
        mstatus      = 64'h8;
        mtvec        = 64'h8000_0101;
        in_valid     = 1'b1;
        in_pc        = 64'h8000_0010;
        in_exception = 1'b1;
        in_cause     = 64'd2;
        in_tval      = 64'hdead;
        in_regwrite  = 1'b1;
        in_dst       = 5'd7;
        in_result    = 64'd55;
        in_csrwrite  = 1'b1;
        in_csraddr   = 12'h305;
        in_csrdata   = 64'd77;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) drive_idle();
            n_checks++;
            if (csr_wen !== 1'b1 || csr_wa !== exp_wa[i] || csr_wd !== exp_wd[i]) begin
                n_fail++;
                $display("FAIL trap_csr%0d: got wen=%b wa=%h wd=%h expected 1 %h %h",
                         i, csr_wen, csr_wa, csr_wd, exp_wa[i], exp_wd[i]);
            end
            n_checks++;
            if (in_ready !== 1'b0 || wen !== 1'b0 || commit_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_busy%0d: got rdy=%b wen=%b cv=%b expected 0 0 0",
                         i, in_ready, wen, commit_valid);
            end
            n_checks++;
            if ({redirect_valid, flush} !== ((i == 3) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL trap_redirect%0d: got rv/flush=%b%b", i, redirect_valid, flush);
            end
            if (i == 3) begin
                n_checks++;
                if (redirect_pc !== 64'h8000_0100) begin
                    n_fail++;
                    $display("FAIL trap_rpc: got %h expected 80000100", redirect_pc);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || {csr_wen, redirect_valid, flush} !== 3'b0) begin
            n_fail++;
            $display("FAIL trap_done: got rdy=%b strobes=%b expected 1 000",
                     in_ready, {csr_wen, redirect_valid, flush});
        end
`ifdef WB_INSTRET_EN
        n_checks++;
        if (instret !== ir0) begin
            n_fail++;
            $display("FAIL trap_instret: got %0d expected %0d", instret, ir0);
        end
`else
        if (ir0 !== 64'd0) $display("note: unexpected instret seed");
`endif
    endtask

    task automatic test_mret();
        mstatus  = 64'h1880;
        mepc     = 64'h8000_0014;
        in_valid = 1'b1;
        in_mret  = 1'b1;
        in_pc    = 64'h8000_0020;
        @(negedge clk);
        drive_idle();
        n_checks++;
        if (csr_wen !== 1'b1 || csr_wa !== 12'h300 || csr_wd !== 64'h88) begin
            n_fail++;
            $display("FAIL mret_csr: got wen=%b wa=%h wd=%h expected 1 300 88",
                     csr_wen, csr_wa, csr_wd);
        end
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0014 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL mret_redirect: got rv=%b rpc=%h flush=%b expected 1 80000014 1",
                     redirect_valid, redirect_pc, flush);
        end
        n_checks++;
        if (commit_valid !== 1'b1 || commit_pc !== 64'h8000_0020 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mret_commit: got cv=%b pc=%h rdy=%b expected 1 80000020 0",
                     commit_valid, commit_pc, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || {csr_wen, redirect_valid, flush, commit_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL mret_done: got rdy=%b strobes=%b expected 1 0000",
                     in_ready, {csr_wen, redirect_valid, flush, commit_valid});
        end
    endtask

    task automatic test_csr_insn();
        logic [11:0] exp_wa [4];
        exp_wa[0] = 12'h341;
        exp_wa[1] = 12'h342;
        exp_wa[2] = 12'h343;
        exp_wa[3] = 12'h300;
        in_valid    = 1'b1;
        in_pc       = 64'h3000;
        in_regwrite = 1'b1;
        in_dst      = 5'd3;
        in_result   = 64'habc;
        in_csrwrite = 1'b1;
        in_csraddr  = 12'h305;
        in_csrdata  = 64'h8000_0000;
        @(negedge clk);
        drive_idle();
        n_checks++;
        if (wen !== 1'b1 || wa !== 5'd3 || csr_wen !== 1'b1 || csr_wa !== 12'h305 ||
            csr_wd !== 64'h8000_0000) begin
            n_fail++;
            $display("FAIL csr_insn: got wen=%b wa=%0d cwen=%b cwa=%h cwd=%h expected 1 3 1 305 80000000",
                     wen, wa, csr_wen, csr_wa, csr_wd);
        end
        @(negedge clk);
        mstatus      = 64'h0;
        mtvec        = 64'h100;
        in_valid     = 1'b1;
        in_pc        = 64'h3004;
        in_regwrite  = 1'b1;
        in_dst       = 5'd3;
        in_result    = 64'habc;
        in_csrwrite  = 1'b1;
        in_csraddr   = 12'h305;
        in_csrdata   = 64'h8000_0000;
        in_exception = 1'b1;
        in_cause     = 64'd8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) drive_idle();
            n_checks++;
            if (wen !== 1'b0 || csr_wen !== 1'b1 || csr_wa !== exp_wa[i]) begin
                n_fail++;
                $display("FAIL csr_trap%0d: got wen=%b cwen=%b cwa=%h expected 0 1 %h",
                         i, wen, csr_wen, csr_wa, exp_wa[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad_writes;
        int not_ready;
        bad_writes   = 0;
        not_ready    = 0;
        mstatus      = 64'h8;
        mtvec        = 64'h200;
        in_valid     = 1'b1;
        in_pc        = 64'h4000;
        in_exception = 1'b1;
        in_cause     = 64'd5;
        in_tval      = 64'h77;
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        n_checks++;
        if (csr_wen !== 1'b1 || csr_wa !== 12'h342) begin
            n_fail++;
            $display("FAIL rmid_cause: got wen=%b wa=%h expected 1 342", csr_wen, csr_wa);
        end
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({wen, csr_wen, redirect_valid, flush, commit_valid} !== 5'b0 ||
            (csr_wd | redirect_pc | commit_pc | wd) !== 64'd0 || csr_wa !== 12'd0) begin
            n_fail++;
            $display("FAIL rmid_clear: got strobes=%b cwa=%h expected 00000 000",
                     {wen, csr_wen, redirect_valid, flush, commit_valid}, csr_wa);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (csr_wen !== 1'b0) bad_writes++;
            if (in_ready !== 1'b1) not_ready++;
        end
        n_checks++;
        if (bad_writes != 0) begin
            n_fail++;
            $display("FAIL rmid_nowrite: got %0d csr writes after reset expected 0", bad_writes);
        end
        n_checks++;
        if (not_ready != 0) begin
            n_fail++;
            $display("FAIL rmid_ready: got %0d not-ready cycles expected 0", not_ready);
        end
    endtask

    task automatic test_random();
        rec_t        q[$];
        rec_t        cur;
        rec_t        r;
        logic [63:0] exp_ir;
        int          errs;
        errs   = 0;
        exp_ir = '0;
        drive_idle();
        do_reset();
        mstatus = {$urandom, $urandom};
        mtvec   = {$urandom, $urandom};
        mepc    = {$urandom, $urandom};
        for (int c = 0; c < 406; c++) begin
            @(negedge clk);
            cur     = '0;
            cur.rdy = 1'b1;
            if (q.size() > 0) cur = q.pop_front();
            n_checks++;
            if (in_ready !== cur.rdy ||
                {wen, csr_wen, redirect_valid, flush, commit_valid} !==
                {cur.wen, cur.csr_wen, cur.rv, cur.flush, cur.cv}) begin
                n_fail++; errs++;
                $display("FAIL rnd_strobes c%0d: got rdy=%b s=%b expected %b %b", c, in_ready,
                         {wen, csr_wen, redirect_valid, flush, commit_valid},
                         cur.rdy, {cur.wen, cur.csr_wen, cur.rv, cur.flush, cur.cv});
            end
            if (cur.wen) begin
                n_checks++;
                if (wa !== cur.wa || wd !== cur.wd) begin
                    n_fail++; errs++;
                    $display("FAIL rnd_gpr c%0d: got %0d %h expected %0d %h",
                             c, wa, wd, cur.wa, cur.wd);
                end
            end
            if (cur.csr_wen) begin
                n_checks++;
                if (csr_wa !== cur.csr_wa || csr_wd !== cur.csr_wd) begin
                    n_fail++; errs++;
                    $display("FAIL rnd_csr c%0d: got %h %h expected %h %h",
                             c, csr_wa, csr_wd, cur.csr_wa, cur.csr_wd);
                end
            end
            if (cur.rv) begin
                n_checks++;
                if (redirect_pc !== cur.rpc) begin
                    n_fail++; errs++;
                    $display("FAIL rnd_rpc c%0d: got %h expected %h", c, redirect_pc, cur.rpc);
                end
            end
            if (cur.cv) begin
                n_checks++;
                if (commit_pc !== cur.cpc) begin
                    n_fail++; errs++;
                    $display("FAIL rnd_cpc c%0d: got %h expected %h", c, commit_pc, cur.cpc);
                end
            end
`ifdef WB_INSTRET_EN
            n_checks++;
            if (instret !== exp_ir) begin
                n_fail++; errs++;
                $display("FAIL rnd_instret c%0d: got %0d expected %0d", c, instret, exp_ir);
            end
`endif
            if (cur.cv) exp_ir++;
            if (errs > 20) begin
                $display("FAIL rnd_abort: too many errors, stopping random phase");
                n_fail++;
                break;
            end

            drive_idle();
            if (c < 400) begin
                in_valid     = ($urandom_range(0, 9) < 7);
                in_pc        = {$urandom, $urandom};
                in_regwrite  = 1'($urandom);
                in_dst       = 5'($urandom);
                in_result    = {$urandom, $urandom};
                in_csrwrite  = ($urandom_range(0, 3) == 0);
                in_csraddr   = 12'($urandom);
                in_csrdata   = {$urandom, $urandom};
                in_exception = ($urandom_range(0, 9) < 2);
                in_cause     = {$urandom, $urandom};
                in_tval      = {$urandom, $urandom};
                in_mret      = ($urandom_range(0, 9) < 2);
            end

            if (in_valid && cur.rdy) begin
                if (in_exception) begin
                    for (int k = 0; k < 4; k++) begin
                        r         = '0;
                        r.csr_wen = 1'b1;
                        case (k)
                            0: begin r.csr_wa = 12'h341; r.csr_wd = in_pc; end
                            1: begin r.csr_wa = 12'h342; r.csr_wd = in_cause; end
                            2: begin r.csr_wa = 12'h343; r.csr_wd = in_tval; end
                            default: begin
                                r.csr_wa = 12'h300;
                                r.csr_wd = model_trap_status(mstatus);
                                r.rv     = 1'b1;
                                r.rpc    = mtvec & 64'hFFFF_FFFF_FFFF_FFFC;
                                r.flush  = 1'b1;
                            end
                        endcase
                        q.push_back(r);
                    end
                end else if (in_mret) begin
                    r         = '0;
                    r.csr_wen = 1'b1;
                    r.csr_wa  = 12'h300;
                    r.csr_wd  = model_mret_status(mstatus);
                    r.rv      = 1'b1;
                    r.rpc     = mepc;
                    r.flush   = 1'b1;
                    r.cv      = 1'b1;
                    r.cpc     = in_pc;
                    q.push_back(r);
                end else begin
                    r         = '0;
                    r.wen     = in_regwrite && (in_dst != 5'd0);
                    r.wa      = in_dst;
                    r.wd      = in_result;
                    r.csr_wen = in_csrwrite;
                    r.csr_wa  = in_csraddr;
                    r.csr_wd  = in_csrdata;
                    r.cv      = 1'b1;
                    r.cpc     = in_pc;
                    r.rdy     = 1'b1;
                    q.push_back(r);
                end
            end
        end
        drive_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        mtvec    = '0;
        mepc     = '0;
        mstatus  = '0;
        drive_idle();
        #1;
        test_reset();
        test_normal();
        test_back_to_back();
        test_trap();
        test_mret();
        test_csr_insn();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
